// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, opcode encodings and the fetch-stage state enum.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [5:0] {
    RTYPE = 6'h00,
    HALT  = 6'h3F
  } opcode_t;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2,
    HALTED  = 2'd3
  } fetch_state_t;

  function automatic logic is_halt(input word_t instr);
    return opcode_t'(instr[31:26]) == HALT;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks to a blocking icache and feeds the
// fetch/decode latch, with a one-word hold register, stale-miss discard and HALT stop.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        ihit_i,
  input  logic [31:0] imemload_i,
  output logic        imemREN_o,
  output logic [31:0] imemaddr_o,
  output logic        valid_o,
  output logic        en_o,
  output logic [31:0] instr_o,
  output logic [31:0] curr_pc_o,
  output logic [31:0] npc_o
);

  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        stale_addr_q, stale_addr_d;
  word_t        hold_instr_q, hold_instr_d;
  word_t        hold_pc_q, hold_pc_d;
  word_t        target;

  assign target = redirect_pc_i & 32'hFFFF_FFFC;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    stale_addr_d = stale_addr_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    imemREN_o    = 1'b0;
    imemaddr_o   = pc_q;
    valid_o      = 1'b0;
    instr_o      = imemload_i;
    curr_pc_o    = pc_q;
    npc_o        = pc_q + 32'd4;

    unique case (state_q)
      FETCH: begin
        imemREN_o = 1'b1;
        valid_o   = ihit_i & ~redirect_i;
        if (redirect_i) begin
          pc_d = target;
          // A pending miss must still be drained before the new address can be issued.
          if (!ihit_i) begin
            stale_addr_d = pc_q;
            state_d      = DISCARD;
          end
        end else if (ihit_i) begin
          pc_d = pc_q + 32'd4;
          if (stall_i) begin
            hold_instr_d = imemload_i;
            hold_pc_d    = pc_q;
            state_d      = HOLD;
          end else if (is_halt(imemload_i)) begin
            state_d = HALTED;
          end
        end
      end

      HOLD: begin
        valid_o   = ~redirect_i;
        instr_o   = hold_instr_q;
        curr_pc_o = hold_pc_q;
        npc_o     = hold_pc_q + 32'd4;
        if (redirect_i) begin
          pc_d    = target;
          state_d = FETCH;
        end else if (!stall_i) begin
          state_d = is_halt(hold_instr_q) ? HALTED : FETCH;
        end
      end

      DISCARD: begin
        imemREN_o  = 1'b1;
        imemaddr_o = stale_addr_q;
        if (redirect_i) pc_d = target;
        if (ihit_i) state_d = FETCH;
      end

      HALTED: begin
        if (redirect_i) begin
          pc_d    = target;
          state_d = FETCH;
        end
      end

      default: state_d = FETCH;
    endcase
  end

  assign en_o = valid_o & ~stall_i;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= FETCH;
      pc_q         <= PC_INIT;
      stale_addr_q <= '0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      stale_addr_q <= stale_addr_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

endmodule
